pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage pipeline. Inspects ID, EX, MEM and WB register addresses.
//  Drives PC/IF-ID write enables, IF-ID and ID-EX flushes (bubble = all ID-EX control bits zero) and a
//  global hold for data-memory wait states. Also produces forwarding selects and a stall-cycle counter.
//  Sits beside the ID/EX pipeline register and the hazard-free datapath; purely control, no data words.
// PARAMETERS
//  CNT_W        16   width of stall_cycles performance counter (saturating)
//  MEM_TIMEOUT  64   max consecutive dmem_busy cycles before fatal timeout (>=1)
// PORTS
//  clk            in   1  rising-edge clock
//  reset_n        in   1  asynchronous, active-low reset
//  id_rs_addr     in   5  rs field of instruction in ID
//  id_rt_addr     in   5  rt field of instruction in ID
//  id_uses_rt     in   1  ID instruction reads rt (R-type, store, branch)
//  ex_rs_addr     in   5  rs address held in ID/EX
//  ex_rt_addr     in   5  rt address held in ID/EX
//  ex_dest_addr   in   5  destination after regDest mux, EX stage
//  ex_regwrite    in   1  RegWrite of EX-stage instruction
//  ex_memread     in   1  MemRead of EX-stage instruction (load)
//  mem_dest_addr  in   5  destination in EX/MEM
//  mem_regwrite   in   1  RegWrite in EX/MEM
//  wb_dest_addr   in   5  destination in MEM/WB
//  wb_regwrite    in   1  RegWrite in MEM/WB
//  ex_redirect    in   1  taken branch or jump resolved in EX
//  dmem_busy      in   1  data memory not ready this cycle
//  clear_cnt      in   1  synchronous clear of stall_cycles
//  pc_write       out  1  PC register load enable
//  ifid_write     out  1  IF/ID load enable
//  ifid_flush     out  1  zero IF/ID instruction next edge
//  idex_flush     out  1  load bubble into ID/EX next edge
//  pipe_hold      out  1  freeze ID/EX, EX/MEM, MEM/WB
//  fwd_a_sel      out  2  ALU A source: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  fwd_b_sel      out  2  ALU B source, same encoding
//  stall_cycles   out  CNT_W  count of cycles with pc_write=0
//  mem_timeout    out  1  sticky fatal error flag
// BEHAVIOUR
//  - State register: RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10. Outputs combinational from state+inputs.
//  - reset_n low: state=RUN, stall_cycles=0, wait counter=0, mem_timeout=0; all outputs 0 while low.
//  - Address 0 never matches (r0 hazards ignored).
//  - Priority in RUN/MEM_WAIT each cycle: dmem_busy > ex_redirect > data hazard > normal.
//  - dmem_busy=1: pc_write=0, ifid_write=0, pipe_hold=1, no flushes; state->MEM_WAIT, wait_cnt++.
//  - MEM_WAIT: when dmem_busy falls, state->RUN the same edge, wait_cnt=0; that cycle evaluated as RUN.
//  - wait_cnt reaching MEM_TIMEOUT with dmem_busy still 1 -> ERROR, mem_timeout=1 (sticky).
//  - ERROR: pc_write=ifid_write=0, pipe_hold=1, flushes 0; left only by reset.
//  - ex_redirect (no busy): pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1 (two wrong-path insts
//    killed). A simultaneous data hazard is ignored: the ID instruction is discarded.
//  - Data hazard (no busy/redirect): pc_write=0, ifid_write=0, idex_flush=1; re-evaluated every cycle.
//  - Normal: pc_write=ifid_write=1, flushes=0, pipe_hold=0.
//  - stall_cycles increments (saturates at all-ones) every cycle pc_write=0 while reset_n high.
//    clear_cnt wins over increment.
//  - Register file is write-first: WB-stage dest never causes a stall.
// CONFIGURATION
//  FORWARDING_EN defined:
//    - hazard = ex_memread & ex_dest!=0 & (ex_dest==id_rs | id_uses_rt & ex_dest==id_rt); 1-cycle bubble.
//    - fwd_a_sel=10 if mem_regwrite & mem_dest!=0 & mem_dest==ex_rs; else 01 if wb equivalent; else 00.
//    - fwd_b_sel likewise on ex_rt; EX/MEM has priority.
//  FORWARDING_EN undefined:
//    - fwd_*_sel tied 00.
//    - hazard = any RAW of id_rs/(id_uses_rt&id_rt) against EX (ex_regwrite) or MEM (mem_regwrite) dest.
//    - Up to 2 stall cycles per dependency.
// TESTING
//  1 reset_n low mid-MEM_WAIT -> all outputs 0 immediately; after release state RUN, counter 0.
//  2 FWD: ex_memread=1, ex_dest=5, id_rs=5 -> one cycle pc_write=0, idex_flush=1, stall_cycles=1.
//  3 no FWD: ex_regwrite=1, ex_dest=3, id_rt=3, id_uses_rt=1 -> 2 stall cycles as inst drains to WB.
//  4 ex_redirect=1 together with load-use hazard -> ifid_flush=idex_flush=1, pc_write=1, no stall.
//  5 FWD: mem_dest=wb_dest=7, both regwrite, ex_rs=7 -> fwd_a_sel=10; mem_regwrite=0 -> 01.
//  6 dmem_busy held 64 cycles -> mem_timeout=1, state ERROR, pipe_hold=1 until reset; 3-cycle busy recovers.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: stage register addresses,
// control bits and the enables/flushes/forward selects returned to the datapath.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic             id_uses_rt;
    logic [4:0]       ex_rs_addr;
    logic [4:0]       ex_rt_addr;
    logic [4:0]       ex_dest_addr;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [4:0]       mem_dest_addr;
    logic             mem_regwrite;
    logic [4:0]       wb_dest_addr;
    logic             wb_regwrite;
    logic             ex_redirect;
    logic             dmem_busy;
    logic             clear_cnt;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             pipe_hold;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_timeout;

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rt, ex_rs_addr, ex_rt_addr, ex_dest_addr,
               ex_regwrite, ex_memread, mem_dest_addr, mem_regwrite, wb_dest_addr,
               wb_regwrite, ex_redirect, dmem_busy, clear_cnt,
        input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, fwd_a_sel,
               fwd_b_sel, stall_cycles, mem_timeout
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rt, ex_rs_addr, ex_rt_addr, ex_dest_addr,
               ex_regwrite, ex_memread, mem_dest_addr, mem_regwrite, wb_dest_addr,
               wb_regwrite, ex_redirect, dmem_busy, clear_cnt,
        output pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, fwd_a_sel,
               fwd_b_sel, stall_cycles, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stalls, flushes, memory holds,
// forwarding selects and a saturating stall counter. Define FORWARDING_EN for the forwarding build.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; hazards and redirects evaluated every cycle
// MEM_WAIT | data memory busy, whole pipe frozen, wait_cnt counting
// ERROR    | memory never answered; pipe frozen until reset
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } state_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_timeout_q;
    logic [CNT_W-1:0]  stall_q;
    logic              hazard;
    logic              pc_write;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    // Register 0 is hardwired, so it can never carry a dependency.
    function automatic logic addr_hit(input logic [4:0] dest, input logic wr, input logic [4:0] src);
        return wr && (dest != 5'd0) && (dest == src);
    endfunction

`ifdef FORWARDING_EN
    logic unused_in;
    assign unused_in = hz.ex_regwrite;

    // Only a load in EX cannot be forwarded in time.
    assign hazard = addr_hit(hz.ex_dest_addr, hz.ex_memread, hz.id_rs_addr)
                  | (hz.id_uses_rt & addr_hit(hz.ex_dest_addr, hz.ex_memread, hz.id_rt_addr));

    assign fwd_a = addr_hit(hz.mem_dest_addr, hz.mem_regwrite, hz.ex_rs_addr) ? 2'b10 :
                   addr_hit(hz.wb_dest_addr,  hz.wb_regwrite,  hz.ex_rs_addr) ? 2'b01 : 2'b00;
    assign fwd_b = addr_hit(hz.mem_dest_addr, hz.mem_regwrite, hz.ex_rt_addr) ? 2'b10 :
                   addr_hit(hz.wb_dest_addr,  hz.wb_regwrite,  hz.ex_rt_addr) ? 2'b01 : 2'b00;
`else
    logic unused_in;
    assign unused_in = ^{hz.ex_memread, hz.ex_rs_addr, hz.ex_rt_addr, hz.wb_dest_addr, hz.wb_regwrite};

    // Without bypass paths, any pending EX or MEM write is a hazard; WB is write-first.
    function automatic logic raw(input logic [4:0] src);
        return addr_hit(hz.ex_dest_addr, hz.ex_regwrite, src)
             | addr_hit(hz.mem_dest_addr, hz.mem_regwrite, src);
    endfunction

    assign hazard = raw(hz.id_rs_addr) | (hz.id_uses_rt & raw(hz.id_rt_addr));
    assign fwd_a  = 2'b00;
    assign fwd_b  = 2'b00;
`endif

    always_comb begin
        pc_write      = 1'b0;
        hz.ifid_write = 1'b0;
        hz.ifid_flush = 1'b0;
        hz.idex_flush = 1'b0;
        hz.pipe_hold  = 1'b0;
        if (!reset_n) begin
            pc_write = 1'b0;
        end else if (state_q == ERROR || hz.dmem_busy) begin
            hz.pipe_hold = 1'b1;
        end else if (hz.ex_redirect) begin
            pc_write      = 1'b1;
            hz.ifid_write = 1'b1;
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
        end else if (hazard) begin
            hz.idex_flush = 1'b1;
        end else begin
            pc_write      = 1'b1;
            hz.ifid_write = 1'b1;
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.fwd_a_sel    = reset_n ? fwd_a : 2'b00;
    assign hz.fwd_b_sel    = reset_n ? fwd_b : 2'b00;
    assign hz.stall_cycles = stall_q;
    assign hz.mem_timeout  = mem_timeout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            wait_cnt      <= '0;
            mem_timeout_q <= 1'b0;
            stall_q       <= '0;
        end else begin
            if (hz.clear_cnt) begin
                stall_q <= '0;
            end else if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end

            case (state_q)
                ERROR: state_q <= ERROR;
                default: begin
                    if (hz.dmem_busy) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                            state_q       <= ERROR;
                            mem_timeout_q <= 1'b1;
                        end else begin
                            state_q <= MEM_WAIT;
                        end
                    end else begin
                        state_q  <= RUN;
                        wait_cnt <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 64;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit m_err;
    int m_wait;
    int m_stall;
    bit e_pcw, e_ifw, e_iff, e_idf, e_hold;
    logic [1:0] e_fa, e_fb;

    function automatic bit dep(input int dest, input bit wr, input int src);
        return wr && dest != 0 && dest == src;
    endfunction

    function automatic logic [1:0] fwd_expect(input int src);
`ifdef FORWARDING_EN
        if (dep(hz.mem_dest_addr, hz.mem_regwrite, src)) return 2'b10;
        if (dep(hz.wb_dest_addr, hz.wb_regwrite, src)) return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic bit hazard_expect();
        bit hit_rs, hit_rt;
`ifdef FORWARDING_EN
        hit_rs = dep(hz.ex_dest_addr, hz.ex_memread, hz.id_rs_addr);
        hit_rt = dep(hz.ex_dest_addr, hz.ex_memread, hz.id_rt_addr);
`else
        hit_rs = dep(hz.ex_dest_addr, hz.ex_regwrite, hz.id_rs_addr) ||
                 dep(hz.mem_dest_addr, hz.mem_regwrite, hz.id_rs_addr);
        hit_rt = dep(hz.ex_dest_addr, hz.ex_regwrite, hz.id_rt_addr) ||
                 dep(hz.mem_dest_addr, hz.mem_regwrite, hz.id_rt_addr);
`endif
        return hit_rs || (hz.id_uses_rt && hit_rt);
    endfunction

    function automatic void model_outputs();
        {e_pcw, e_ifw, e_iff, e_idf, e_hold} = 5'b0;
        e_fa = 2'b00;
        e_fb = 2'b00;
        if (reset_n !== 1'b1) return;
        e_fa = fwd_expect(hz.ex_rs_addr);
        e_fb = fwd_expect(hz.ex_rt_addr);
        if (m_err || hz.dmem_busy) e_hold = 1;
        else if (hz.ex_redirect) {e_pcw, e_ifw, e_iff, e_idf} = 4'b1111;
        else if (hazard_expect()) e_idf = 1;
        else {e_pcw, e_ifw} = 2'b11;
    endfunction

    function automatic void model_reset();
        m_err = 0;
        m_wait = 0;
        m_stall = 0;
    endfunction

    function automatic void model_step();
        if (reset_n !== 1'b1) begin
            model_reset();
            return;
        end
        model_outputs();
        if (hz.clear_cnt) m_stall = 0;
        else if (!e_pcw && m_stall < CNT_MAX) m_stall++;
        if (!m_err) begin
            if (hz.dmem_busy) begin
                m_wait++;
                if (m_wait >= MEM_TIMEOUT) m_err = 1;
            end else begin
                m_wait = 0;
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        hz.id_rs_addr = 0; hz.id_rt_addr = 0; hz.id_uses_rt = 0;
        hz.ex_rs_addr = 0; hz.ex_rt_addr = 0; hz.ex_dest_addr = 0;
        hz.ex_regwrite = 0; hz.ex_memread = 0;
        hz.mem_dest_addr = 0; hz.mem_regwrite = 0;
        hz.wb_dest_addr = 0; hz.wb_regwrite = 0;
        hz.ex_redirect = 0; hz.dmem_busy = 0; hz.clear_cnt = 0;
    endtask

    // load in EX writing r9 read by ID: a hazard in both builds
    task automatic load_use_hazard();
        hz.ex_memread = 1; hz.ex_regwrite = 1; hz.ex_dest_addr = 9; hz.id_rs_addr = 9;
    endtask

    task automatic clear_counter();
        idle_inputs();
        hz.clear_cnt = 1;
        tick();
        hz.clear_cnt = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        model_reset();
        #1;
        checks++;
        if ({hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush, hz.pipe_hold} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush, hz.pipe_hold});
        end
        checks++;
        if (hz.stall_cycles !== '0 || hz.mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs stall=%0d timeout=%b exp 0/0", hz.stall_cycles, hz.mem_timeout);
        end
        @(negedge clk);
        reset_n = 1;
        #1;
        checks++;
        if (hz.pc_write !== 1'b1) begin
            failures++;
            $display("FAIL reset_release pc_write got=%b exp=1", hz.pc_write);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        hz.dmem_busy = 1;
        repeat (3) tick();
        #1;
        checks++;
        if (hz.pipe_hold !== 1'b1 || hz.stall_cycles !== CNT_W'(m_stall)) begin
            failures++;
            $display("FAIL wait_before_reset hold=%b stall=%0d exp hold=1 stall=%0d",
                     hz.pipe_hold, hz.stall_cycles, m_stall);
        end
        #2;
        reset_n = 0;
        model_reset();
        #1;
        checks++;
        if ({hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush, hz.pipe_hold,
             hz.fwd_a_sel, hz.fwd_b_sel, hz.mem_timeout} !== 10'b0 || hz.stall_cycles !== '0) begin
            failures++;
            $display("FAIL reset_mid_wait hold=%b pcw=%b stall=%0d exp all zero",
                     hz.pipe_hold, hz.pc_write, hz.stall_cycles);
        end
        @(negedge clk);
        reset_n = 1;
        hz.dmem_busy = 0;
        #1;
        checks++;
        if (hz.pc_write !== 1'b1 || hz.pipe_hold !== 1'b0 || hz.stall_cycles !== '0) begin
            failures++;
            $display("FAIL after_reset_run pcw=%b hold=%b stall=%0d exp 1/0/0",
                     hz.pc_write, hz.pipe_hold, hz.stall_cycles);
        end
        tick();
    endtask

    task automatic test_data_hazard();
        clear_counter();
`ifdef FORWARDING_EN
        hz.ex_memread = 1; hz.ex_regwrite = 1; hz.ex_dest_addr = 5; hz.id_rs_addr = 5;
        #1;
        checks++;
        if (hz.pc_write !== 1'b0 || hz.idex_flush !== 1'b1 || hz.ifid_write !== 1'b0) begin
            failures++;
            $display("FAIL load_use_stall pcw=%b idex_flush=%b exp 0/1", hz.pc_write, hz.idex_flush);
        end
        tick();
        idle_inputs();
        hz.mem_dest_addr = 5; hz.mem_regwrite = 1; hz.id_rs_addr = 5;
        #1;
        checks++;
        if (hz.pc_write !== 1'b1 || hz.stall_cycles !== CNT_W'(1)) begin
            failures++;
            $display("FAIL load_use_release pcw=%b stall=%0d exp 1/1", hz.pc_write, hz.stall_cycles);
        end
        tick();
`else
        hz.ex_regwrite = 1; hz.ex_dest_addr = 3; hz.id_rt_addr = 3; hz.id_uses_rt = 1;
        #1;
        checks++;
        if (hz.pc_write !== 1'b0 || hz.idex_flush !== 1'b1 || hz.ifid_write !== 1'b0) begin
            failures++;
            $display("FAIL raw_ex_stall pcw=%b idex_flush=%b exp 0/1", hz.pc_write, hz.idex_flush);
        end
        tick();
        hz.ex_regwrite = 0; hz.ex_dest_addr = 0; hz.mem_dest_addr = 3; hz.mem_regwrite = 1;
        #1;
        checks++;
        if (hz.pc_write !== 1'b0 || hz.idex_flush !== 1'b1) begin
            failures++;
            $display("FAIL raw_mem_stall pcw=%b idex_flush=%b exp 0/1", hz.pc_write, hz.idex_flush);
        end
        tick();
        hz.mem_regwrite = 0; hz.mem_dest_addr = 0; hz.wb_dest_addr = 3; hz.wb_regwrite = 1;
        #1;
        checks++;
        if (hz.pc_write !== 1'b1 || hz.stall_cycles !== CNT_W'(2)) begin
            failures++;
            $display("FAIL raw_wb_release pcw=%b stall=%0d exp 1/2", hz.pc_write, hz.stall_cycles);
        end
        tick();
`endif
        idle_inputs();
        hz.ex_memread = 1; hz.ex_regwrite = 1; hz.mem_regwrite = 1;
        hz.id_rs_addr = 0; hz.id_rt_addr = 0; hz.id_uses_rt = 1;
        #1;
        checks++;
        if (hz.pc_write !== 1'b1) begin
            failures++;
            $display("FAIL r0_no_hazard pcw=%b exp=1", hz.pc_write);
        end
        tick();
        idle_inputs();
        hz.ex_memread = 1; hz.ex_regwrite = 1; hz.ex_dest_addr = 12; hz.id_rt_addr = 12;
        hz.id_uses_rt = 0;
        #1;
        checks++;
        if (hz.pc_write !== 1'b1) begin
            failures++;
            $display("FAIL rt_unused_no_hazard pcw=%b exp=1", hz.pc_write);
        end
        tick();
    endtask

    task automatic test_redirect();
        clear_counter();
        load_use_hazard();
        hz.ex_redirect = 1;
        #1;
        checks++;
        if ({hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush, hz.pipe_hold} !== 5'b11110) begin
            failures++;
            $display("FAIL redirect_over_hazard got=%b exp=11110",
                     {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush, hz.pipe_hold});
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hz.stall_cycles !== '0) begin
            failures++;
            $display("FAIL redirect_no_stall stall=%0d exp=0", hz.stall_cycles);
        end
        tick();
    endtask

    task automatic test_forwarding();
        logic [1:0] exp_mem, exp_wb;
`ifdef FORWARDING_EN
        exp_mem = 2'b10; exp_wb = 2'b01;
`else
        exp_mem = 2'b00; exp_wb = 2'b00;
`endif
        idle_inputs();
        hz.ex_rs_addr = 7; hz.ex_rt_addr = 7;
        hz.mem_dest_addr = 7; hz.mem_regwrite = 1; hz.wb_dest_addr = 7; hz.wb_regwrite = 1;
        #1;
        checks++;
        if (hz.fwd_a_sel !== exp_mem || hz.fwd_b_sel !== exp_mem) begin
            failures++;
            $display("FAIL fwd_mem_priority a=%b b=%b exp=%b", hz.fwd_a_sel, hz.fwd_b_sel, exp_mem);
        end
        tick();
        hz.mem_regwrite = 0;
        #1;
        checks++;
        if (hz.fwd_a_sel !== exp_wb || hz.fwd_b_sel !== exp_wb) begin
            failures++;
            $display("FAIL fwd_wb a=%b b=%b exp=%b", hz.fwd_a_sel, hz.fwd_b_sel, exp_wb);
        end
        tick();
        hz.wb_dest_addr = 0; hz.ex_rs_addr = 0;
        #1;
        checks++;
        if (hz.fwd_a_sel !== 2'b00) begin
            failures++;
            $display("FAIL fwd_none a=%b exp=00", hz.fwd_a_sel);
        end
        tick();
    endtask

    task automatic test_saturation();
        clear_counter();
        load_use_hazard();
        repeat (CNT_MAX + 4) tick();
        #1;
        checks++;
        if (hz.stall_cycles !== CNT_W'(CNT_MAX)) begin
            failures++;
            $display("FAIL stall_saturate got=%0d exp=%0d", hz.stall_cycles, CNT_MAX);
        end
        hz.clear_cnt = 1;
        tick();
        hz.clear_cnt = 0;
        idle_inputs();
        #1;
        checks++;
        if (hz.stall_cycles !== '0) begin
            failures++;
            $display("FAIL clear_beats_inc got=%0d exp=0", hz.stall_cycles);
        end
        tick();
    endtask

    task automatic test_timeout();
        idle_inputs();
        hz.dmem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (hz.pipe_hold !== 1'b1 || hz.pc_write !== 1'b0 || hz.idex_flush !== 1'b0) begin
                failures++;
                $display("FAIL busy_hold[%0d] hold=%b pcw=%b exp 1/0", i, hz.pipe_hold, hz.pc_write);
            end
            tick();
        end
        hz.dmem_busy = 0;
        #1;
        checks++;
        if (hz.pc_write !== 1'b1 || hz.pipe_hold !== 1'b0) begin
            failures++;
            $display("FAIL busy_recover pcw=%b hold=%b exp 1/0", hz.pc_write, hz.pipe_hold);
        end
        tick();
        hz.dmem_busy = 1;
        repeat (MEM_TIMEOUT - 1) tick();
        hz.dmem_busy = 0;
        #1;
        checks++;
        if (hz.mem_timeout !== 1'b0 || hz.pc_write !== 1'b1) begin
            failures++;
            $display("FAIL busy_just_below_limit timeout=%b pcw=%b exp 0/1", hz.mem_timeout, hz.pc_write);
        end
        tick();
        hz.dmem_busy = 1;
        repeat (MEM_TIMEOUT) tick();
        hz.dmem_busy = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (hz.mem_timeout !== 1'b1 || hz.pipe_hold !== 1'b1 || hz.pc_write !== 1'b0 ||
                hz.ifid_flush !== 1'b0) begin
                failures++;
                $display("FAIL error_sticky[%0d] timeout=%b hold=%b pcw=%b exp 1/1/0",
                         i, hz.mem_timeout, hz.pipe_hold, hz.pc_write);
            end
            tick();
        end
        reset_n = 0;
        model_reset();
        #1;
        checks++;
        if (hz.mem_timeout !== 1'b0 || hz.pipe_hold !== 1'b0) begin
            failures++;
            $display("FAIL error_reset timeout=%b hold=%b exp 0/0", hz.mem_timeout, hz.pipe_hold);
        end
        @(negedge clk);
        reset_n = 1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            hz.id_rs_addr    = 5'($urandom_range(0, 3));
            hz.id_rt_addr    = 5'($urandom_range(0, 3));
            hz.id_uses_rt    = 1'($urandom_range(0, 1));
            hz.ex_rs_addr    = 5'($urandom_range(0, 3));
            hz.ex_rt_addr    = 5'($urandom_range(0, 3));
            hz.ex_dest_addr  = 5'($urandom_range(0, 3));
            hz.ex_regwrite   = 1'($urandom_range(0, 1));
            hz.ex_memread    = 1'($urandom_range(0, 1));
            hz.mem_dest_addr = 5'($urandom_range(0, 3));
            hz.mem_regwrite  = 1'($urandom_range(0, 1));
            hz.wb_dest_addr  = 5'($urandom_range(0, 3));
            hz.wb_regwrite   = 1'($urandom_range(0, 1));
            hz.ex_redirect   = ($urandom_range(0, 5) == 0);
            hz.dmem_busy     = ($urandom_range(0, 5) == 0);
            hz.clear_cnt     = ($urandom_range(0, 15) == 0);
            #1;
            model_outputs();
            checks++;
            if ({hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush, hz.pipe_hold} !==
                {e_pcw, e_ifw, e_iff, e_idf, e_hold}) begin
                failures++;
                $display("FAIL rand_ctrl[%0d] got=%b exp=%b", i,
                         {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush, hz.pipe_hold},
                         {e_pcw, e_ifw, e_iff, e_idf, e_hold});
            end
            checks++;
            if (hz.fwd_a_sel !== e_fa || hz.fwd_b_sel !== e_fb) begin
                failures++;
                $display("FAIL rand_fwd[%0d] got=%b/%b exp=%b/%b", i, hz.fwd_a_sel, hz.fwd_b_sel, e_fa, e_fb);
            end
            checks++;
            if (hz.stall_cycles !== CNT_W'(m_stall) || hz.mem_timeout !== m_err) begin
                failures++;
                $display("FAIL rand_regs[%0d] stall=%0d timeout=%b exp %0d/%b", i,
                         hz.stall_cycles, hz.mem_timeout, m_stall, m_err);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_data_hazard();
        test_redirect();
        test_forwarding();
        test_saturation();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
